// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler
//   Brings a free-running, glitchy ripple-counter value into the clk domain.
//   Transient codes are filtered out. Count increments, including wrap-around,
//   are accumulated into a wide extended count. Snapshots of that count are
//   offered to a downstream consumer over a valid/ready handshake.
//
// Optional feature: define SAMPLER_MISS_CNT_EN to add the miss_cnt output.
//   miss_cnt counts sample requests dropped while a snapshot is pending.
//
// Ports:
//   clk        system clock; all logic runs on the rising edge
//   rst        asynchronous reset, active low
//   cnt_in     raw ripple counter value, asynchronous to clk
//   sample_req single-cycle request to snapshot ext_cnt
//   clr        synchronous clear of the accumulator and ovf
//   out_ready  downstream ready
//   out_valid  snapshot available
//   out_data   snapshot of ext_cnt
//   ext_cnt    live extended count
//   ovf        sticky flag, set when ext_cnt wraps past 2^EXT_W-1
//   miss_cnt   (SAMPLER_MISS_CNT_EN only) saturating count of dropped requests
module ripple_count_sampler #(
  parameter int CNT_W    = 4,
  parameter int EXT_W    = 16,
  parameter int STABLE_N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             sample_req,
  input  logic             clr,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [EXT_W-1:0] out_data,
  output logic [EXT_W-1:0] ext_cnt,
  output logic             ovf
`ifdef SAMPLER_MISS_CNT_EN
  ,
  output logic [7:0]       miss_cnt
`endif
);

  typedef enum logic {ST_INIT, ST_RUN} acc_state_e;

  // The first synchroniser stage feeds a history window. Entry 0 of the window
  // is the second synchroniser flop, so the window holds the last STABLE_N
  // synchronised samples. Each entry carries a fill bit. Without it, the zeros
  // left by reset would qualify as a real code before the counter is sampled.
  logic [CNT_W-1:0] sync1_q, sync1_d;
  logic             sync1_vld_q, sync1_vld_d;
  logic [CNT_W-1:0] win_q [STABLE_N];
  logic [CNT_W-1:0] win_d [STABLE_N];
  logic [STABLE_N-1:0] win_vld_q, win_vld_d;

  acc_state_e       state_q, state_d;
  logic [CNT_W-1:0] base_q, base_d;
  logic [EXT_W-1:0] ext_q, ext_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [EXT_W-1:0] out_data_q, out_data_d;

  logic             qual;
  logic [CNT_W-1:0] q_code;
  logic [CNT_W-1:0] delta;
  logic [EXT_W:0]   sum;

  // Synchroniser and history shift.
  always_comb begin
    sync1_d     = cnt_in;
    sync1_vld_d = 1'b1;
    win_d[0]     = sync1_q;
    win_vld_d[0] = sync1_vld_q;
    for (int i = 1; i < STABLE_N; i++) begin
      win_d[i]     = win_q[i-1];
      win_vld_d[i] = win_vld_q[i-1];
    end
  end

  // A code qualifies when every filled window entry matches the newest one.
  always_comb begin
    q_code = win_q[0];
    qual   = &win_vld_q;
    for (int i = 1; i < STABLE_N; i++) begin
      if (win_q[i] != win_q[0]) qual = 1'b0;
    end
  end

  // The modular subtraction handles counter wrap. The wider sum exposes the
  // carry out of the extended count.
  always_comb begin
    delta = q_code - base_q;
    sum   = {1'b0, ext_q} + (EXT_W+1)'(delta);
  end

  // Accumulator FSM. When clr and a new code land on the same edge, the
  // baseline still follows the code so that the increment is not counted again.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    ext_d   = ext_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_INIT: begin
        if (qual && !clr) begin
          base_d  = q_code;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (qual && (q_code != base_q)) begin
          base_d = q_code;
          if (!clr) begin
            ext_d = sum[EXT_W-1:0];
            if (sum[EXT_W]) ovf_d = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
    if (clr) begin
      ext_d = '0;
      ovf_d = 1'b0;
    end
  end

  // Snapshot handshake. A request arriving while a snapshot is pending,
  // including on the completion edge, is dropped.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (!out_valid_q) begin
      if (sample_req) begin
        out_valid_d = 1'b1;
        out_data_d  = ext_q;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= '0;
      sync1_vld_q <= 1'b0;
      for (int i = 0; i < STABLE_N; i++) win_q[i] <= '0;
      win_vld_q   <= '0;
      state_q     <= ST_INIT;
      base_q      <= '0;
      ext_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync1_vld_q <= sync1_vld_d;
      for (int i = 0; i < STABLE_N; i++) win_q[i] <= win_d[i];
      win_vld_q   <= win_vld_d;
      state_q     <= state_d;
      base_q      <= base_d;
      ext_q       <= ext_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign ext_cnt   = ext_q;
  assign ovf       = ovf_q;

`ifdef SAMPLER_MISS_CNT_EN
  logic [7:0] miss_q, miss_d;

  // Saturating count of dropped sample requests.
  always_comb begin
    miss_d = miss_q;
    if (clr) begin
      miss_d = '0;
    end else if (sample_req && out_valid_q && (miss_q != 8'hFF)) begin
      miss_d = miss_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) miss_q <= '0;
    else      miss_q <= miss_d;
  end

  assign miss_cnt = miss_q;
`endif

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Directed testbench for ripple_count_sampler.
// The bench drives a default instance (EXT_W=16) and an 8-bit instance from
// the same inputs. The 8-bit instance lets overflow be reached quickly.
module tb_ripple_count_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cnt_in;
  logic        sample_req;
  logic        clr;
  logic        out_ready;

  logic        out_valid, ovf;
  logic [15:0] out_data, ext_cnt;
  logic        out_valid8, ovf8;
  logic [7:0]  out_data8, ext_cnt8;
`ifdef SAMPLER_MISS_CNT_EN
  logic [7:0]  miss_cnt, miss_cnt8;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ripple_count_sampler dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .sample_req(sample_req),
    .clr(clr), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .ext_cnt(ext_cnt), .ovf(ovf)
`ifdef SAMPLER_MISS_CNT_EN
    , .miss_cnt(miss_cnt)
`endif
  );

  ripple_count_sampler #(.CNT_W(4), .EXT_W(8), .STABLE_N(2)) dut8 (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .sample_req(sample_req),
    .clr(clr), .out_ready(out_ready), .out_valid(out_valid8),
    .out_data(out_data8), .ext_cnt(ext_cnt8), .ovf(ovf8)
`ifdef SAMPLER_MISS_CNT_EN
    , .miss_cnt(miss_cnt8)
`endif
  );

  // Advance n rising edges, then settle 1ns past the edge for drive/sample
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; cnt_in = 4'h3; sample_req = 1'b0; clr = 1'b0; out_ready = 1'b0;
    step(2);
    n_vec++;
    if (ext_cnt !== 16'd0 || ovf !== 1'b0) begin
      n_err++; $display("[TB] FAIL reset_acc: ext_cnt=%0d ovf=%0b, want 0/0", ext_cnt, ovf);
    end
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 16'd0) begin
      n_err++; $display("[TB] FAIL reset_out: valid=%0b data=%0d, want 0/0", out_valid, out_data);
    end
    rst = 1'b1;
    step(8);
    // Baseline must be 3; the cleared synchroniser must not count as code 0
    n_vec++;
    if (ext_cnt !== 16'd0) begin
      n_err++; $display("[TB] FAIL init_baseline: ext_cnt=%0d, want 0", ext_cnt);
    end
  endtask

  task automatic test_counting;
    for (int c = 4; c <= 18; c++) begin
      cnt_in = 4'(c);
      step(8);
      if (c == 15) begin
        n_vec++;
        if (ext_cnt !== 16'd12) begin
          n_err++; $display("[TB] FAIL count_to_F: ext_cnt=%0d, want 12", ext_cnt);
        end
      end
    end
    n_vec++;
    if (ext_cnt !== 16'd15 || ovf !== 1'b0) begin
      n_err++; $display("[TB] FAIL count_wrap: ext_cnt=%0d ovf=%0b, want 15/0", ext_cnt, ovf);
    end
  endtask

  task automatic test_glitch;
    cnt_in = 4'h7;
    step(8);
    n_vec++;
    if (ext_cnt !== 16'd20) begin
      n_err++; $display("[TB] FAIL jump_to_7: ext_cnt=%0d, want 20", ext_cnt);
    end
    cnt_in = 4'hF;
    step(1);
    cnt_in = 4'h8;
    step(8);
    n_vec++;
    if (ext_cnt !== 16'd21) begin
      n_err++; $display("[TB] FAIL glitch_filter: ext_cnt=%0d, want 21", ext_cnt);
    end
  endtask

  task automatic test_handshake;
    sample_req = 1'b1;
    step(1);
    sample_req = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 16'd21) begin
      n_err++; $display("[TB] FAIL snap_take: valid=%0b data=%0d, want 1/21", out_valid, out_data);
    end
    // Live count moves on while the pending snapshot must hold
    cnt_in = 4'h9;
    for (int k = 0; k < 5; k++) begin
      step(1);
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 16'd21) begin
        n_err++; $display("[TB] FAIL snap_hold%0d: valid=%0b data=%0d, want 1/21", k, out_valid, out_data);
      end
    end
    step(3);
    n_vec++;
    if (ext_cnt !== 16'd22) begin
      n_err++; $display("[TB] FAIL live_update: ext_cnt=%0d, want 22", ext_cnt);
    end
    sample_req = 1'b1;
    step(1);
    sample_req = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 16'd21) begin
      n_err++; $display("[TB] FAIL snap_drop: valid=%0b data=%0d, want 1/21", out_valid, out_data);
    end
`ifdef SAMPLER_MISS_CNT_EN
    n_vec++;
    if (miss_cnt !== 8'd1) begin
      n_err++; $display("[TB] FAIL miss_one: miss_cnt=%0d, want 1", miss_cnt);
    end
`endif
    // A request on the completion edge is dropped
    out_ready = 1'b1; sample_req = 1'b1;
    step(1);
    out_ready = 1'b0; sample_req = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL snap_done: valid=%0b, want 0", out_valid);
    end
`ifdef SAMPLER_MISS_CNT_EN
    n_vec++;
    if (miss_cnt !== 8'd2) begin
      n_err++; $display("[TB] FAIL miss_done_edge: miss_cnt=%0d, want 2", miss_cnt);
    end
`endif
    step(1);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL no_relatch: valid=%0b, want 0", out_valid);
    end
    sample_req = 1'b1;
    step(1);
    sample_req = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 16'd22) begin
      n_err++; $display("[TB] FAIL snap_second: valid=%0b data=%0d, want 1/22", out_valid, out_data);
    end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL snap_second_done: valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_clr_collide;
    cnt_in = 4'h5;
    step(8);
    n_vec++;
    if (ext_cnt !== 16'd34) begin
      n_err++; $display("[TB] FAIL back_wrap: ext_cnt=%0d, want 34", ext_cnt);
    end
    // Code 9 qualifies on the 4th edge after it is driven; clr meets it there
    cnt_in = 4'h9;
    step(3);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    n_vec++;
    if (ext_cnt !== 16'd0 || ovf !== 1'b0) begin
      n_err++; $display("[TB] FAIL clr_collide: ext_cnt=%0d ovf=%0b, want 0/0", ext_cnt, ovf);
    end
`ifdef SAMPLER_MISS_CNT_EN
    n_vec++;
    if (miss_cnt !== 8'd0) begin
      n_err++; $display("[TB] FAIL miss_clr: miss_cnt=%0d, want 0", miss_cnt);
    end
`endif
    step(4);
    n_vec++;
    if (ext_cnt !== 16'd0) begin
      n_err++; $display("[TB] FAIL clr_baseline: ext_cnt=%0d, want 0", ext_cnt);
    end
    cnt_in = 4'hA;
    step(8);
    n_vec++;
    if (ext_cnt !== 16'd1 || ext_cnt8 !== 8'd1) begin
      n_err++; $display("[TB] FAIL after_clr: ext_cnt=%0d ext_cnt8=%0d, want 1/1", ext_cnt, ext_cnt8);
    end
  endtask

  task automatic test_overflow;
    logic [3:0] code;
    code = 4'hA;
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    for (int i = 1; i <= 259; i++) begin
      code = code + 4'd1;
      cnt_in = code;
      step(4);
      if (i == 255) begin
        n_vec++;
        if (ext_cnt8 !== 8'd255 || ovf8 !== 1'b0) begin
          n_err++; $display("[TB] FAIL ovf_edge: ext_cnt8=%0d ovf8=%0b, want 255/0", ext_cnt8, ovf8);
        end
      end
      if (i == 256) begin
        n_vec++;
        if (ext_cnt8 !== 8'd0 || ovf8 !== 1'b1) begin
          n_err++; $display("[TB] FAIL ovf_wrap: ext_cnt8=%0d ovf8=%0b, want 0/1", ext_cnt8, ovf8);
        end
        n_vec++;
        if (ext_cnt !== 16'd256 || ovf !== 1'b0) begin
          n_err++; $display("[TB] FAIL wide_no_ovf: ext_cnt=%0d ovf=%0b, want 256/0", ext_cnt, ovf);
        end
      end
    end
    n_vec++;
    if (ext_cnt8 !== 8'd3 || ovf8 !== 1'b1) begin
      n_err++; $display("[TB] FAIL ovf_sticky: ext_cnt8=%0d ovf8=%0b, want 3/1", ext_cnt8, ovf8);
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    n_vec++;
    if (ext_cnt8 !== 8'd0 || ovf8 !== 1'b0) begin
      n_err++; $display("[TB] FAIL ovf_clr: ext_cnt8=%0d ovf8=%0b, want 0/0", ext_cnt8, ovf8);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset;
    test_counting;
    test_glitch;
    test_handshake;
    test_clr_collide;
    test_overflow;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
